// File: rtl/mod_add.sv
// Registered modular adder: M = (A + B) mod q, two-stage free-running pipeline.
// Stage 1 registers the full-width sum; stage 2 reduces it with a restoring-division array.
module mod_add #(
  parameter int BIT_SIZE = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [BIT_SIZE-1:0] A,
  input  logic [BIT_SIZE-1:0] B,
  input  logic [BIT_SIZE-1:0] q,
  output logic [BIT_SIZE-1:0] M
);

  logic [BIT_SIZE:0]   s_p0;
  logic [BIT_SIZE-1:0] q_p0;
  logic [BIT_SIZE-1:0] r_p1;

  // Unrolled restoring division, MSB first; only the remainder is kept.
  // A zero modulus yields zero; the top remainder bit can only be set in that case.
  function automatic logic [BIT_SIZE-1:0] mod_reduce(
    input logic [BIT_SIZE:0]   s,
    input logic [BIT_SIZE-1:0] d
  );
    logic [BIT_SIZE:0] rem;
    logic [BIT_SIZE:0] trial;
    logic [BIT_SIZE:0] dw;
    rem = '0;
    dw  = {1'b0, d};
    for (int i = BIT_SIZE; i >= 0; i--) begin
      trial = {rem[BIT_SIZE-1:0], s[i]};
      if (trial >= dw) rem = trial - dw;
      else             rem = trial;
    end
    if ((d == '0) || rem[BIT_SIZE]) return '0;
    return rem[BIT_SIZE-1:0];
  endfunction

  // Stage 1: full-width sum and modulus capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_p0 <= '0;
      q_p0 <= '0;
    end else begin
      s_p0 <= {1'b0, A} + {1'b0, B};
      q_p0 <= q;
    end
  end

  assign r_p1 = mod_reduce(s_p0, q_p0);

  // Stage 2: registered remainder
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) M <= '0;
    else       M <= r_p1;
  end

endmodule

// File: tb/tb_mod_add.sv
// Directed and random checks of mod_add at BIT_SIZE 4 and 8.
module tb_mod_add;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] a4, b4, q4, m4;
  logic [7:0] a8, b8, q8, m8;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_add #(.BIT_SIZE(4)) dut4 (.clk(clk), .rstn(rstn), .A(a4), .B(b4), .q(q4), .M(m4));
  mod_add #(.BIT_SIZE(8)) dut8 (.clk(clk), .rstn(rstn), .A(a8), .B(b8), .q(q8), .M(m8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    a4 = 4'd8; b4 = 4'd3; q4 = 4'd2;
    a8 = '0; b8 = '0; q8 = 8'd1;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (m4 !== 4'd0) begin errors++; $display("FAIL reset_async: M=%0d expected 0", m4); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (m4 !== 4'd0) begin errors++; $display("FAIL reset_hold%0d: M=%0d expected 0", i, m4); end
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (m4 !== 4'd0) begin errors++; $display("FAIL reset_release_e1: M=%0d expected 0", m4); end
    tick();
    checks++;
    if (m4 !== 4'd1) begin errors++; $display("FAIL reset_release_e2: M=%0d expected 1", m4); end
  endtask

  task automatic test_exceed_modulus();
    logic [3:0] va[3] = '{4'd8, 4'd5, 4'd12};
    logic [3:0] vb[3] = '{4'd3, 4'd7, 4'd6};
    logic [3:0] vq[3] = '{4'd2, 4'd3, 4'd4};
    logic [3:0] ve[3] = '{4'd1, 4'd0, 4'd2};
    for (int i = 0; i < 3; i++) begin
      a4 = va[i]; b4 = vb[i]; q4 = vq[i];
      tick();
      tick();
      checks++;
      if (m4 !== ve[i])
        begin errors++; $display("FAIL exceed%0d: M=%0d expected %0d", i, m4, ve[i]); end
    end
  endtask

  task automatic test_boundaries();
    logic [3:0] va[5] = '{4'd5, 4'd9, 4'd15, 4'd15, 4'd2};
    logic [3:0] vb[5] = '{4'd6, 4'd4, 4'd15, 4'd15, 4'd3};
    logic [3:0] vq[5] = '{4'd0, 4'd1, 4'd15, 4'd7, 4'd11};
    logic [3:0] ve[5] = '{4'd0, 4'd0, 4'd0, 4'd2, 4'd5};
    for (int i = 0; i < 5; i++) begin
      a4 = va[i]; b4 = vb[i]; q4 = vq[i];
      tick();
      tick();
      checks++;
      if (m4 !== ve[i])
        begin errors++; $display("FAIL boundary%0d: M=%0d expected %0d", i, m4, ve[i]); end
    end
    // Full-scale at width 8: 510 mod 255 = 0, 510 mod 7 = 6
    a8 = 8'd255; b8 = 8'd255; q8 = 8'd7;
    tick();
    tick();
    checks++;
    if (m8 !== 8'd6) begin errors++; $display("FAIL boundary8_fullscale: M=%0d expected 6", m8); end
  endtask

  task automatic test_back_to_back();
    a4 = 4'd8; b4 = 4'd3; q4 = 4'd2;
    tick();
    a4 = 4'd5; b4 = 4'd7; q4 = 4'd3;
    tick();
    checks++;
    if (m4 !== 4'd1) begin errors++; $display("FAIL b2b0: M=%0d expected 1", m4); end
    a4 = 4'd12; b4 = 4'd6; q4 = 4'd4;
    tick();
    checks++;
    if (m4 !== 4'd0) begin errors++; $display("FAIL b2b1: M=%0d expected 0", m4); end
    tick();
    checks++;
    if (m4 !== 4'd2) begin errors++; $display("FAIL b2b2: M=%0d expected 2", m4); end
  endtask

  task automatic test_async_reset_midstream();
    a4 = 4'd8; b4 = 4'd3; q4 = 4'd2;
    tick();
    a4 = 4'd12; b4 = 4'd6; q4 = 4'd4;
    tick();
    checks++;
    if (m4 !== 4'd1) begin errors++; $display("FAIL midrst_pre: M=%0d expected 1", m4); end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (m4 !== 4'd0) begin errors++; $display("FAIL midrst_drop: M=%0d expected 0", m4); end
    a4 = 4'd2; b4 = 4'd3; q4 = 4'd11;
    #1 rstn = 1'b1;
    tick();
    checks++;
    if (m4 !== 4'd0) begin errors++; $display("FAIL midrst_stale: M=%0d expected 0", m4); end
    tick();
    checks++;
    if (m4 !== 4'd5) begin errors++; $display("FAIL midrst_resume: M=%0d expected 5", m4); end
  endtask

  task automatic test_random();
    int n = 10000;
    int exp4[$];
    int exp8[$];
    int e4, e8;
    int printed = 0;
    for (int i = 0; i < n + 1; i++) begin
      if (i < n) begin
        a4 = 4'($urandom_range(15, 0));
        b4 = 4'($urandom_range(15, 0));
        q4 = 4'($urandom_range(15, 1));
        a8 = 8'($urandom_range(255, 0));
        b8 = 8'($urandom_range(255, 0));
        q8 = 8'($urandom_range(255, 1));
        exp4.push_back((int'(a4) + int'(b4)) % int'(q4));
        exp8.push_back((int'(a8) + int'(b8)) % int'(q8));
      end
      tick();
      if (i >= 1) begin
        e4 = exp4.pop_front();
        e8 = exp8.pop_front();
        checks++;
        if (int'(m4) != e4) begin
          errors++;
          if (printed < 10) begin printed++; $display("FAIL random4[%0d]: M=%0d expected %0d", i, m4, e4); end
        end
        checks++;
        if (int'(m8) != e8) begin
          errors++;
          if (printed < 10) begin printed++; $display("FAIL random8[%0d]: M=%0d expected %0d", i, m8, e8); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_exceed_modulus();
    test_boundaries();
    test_back_to_back();
    test_async_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
